// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register with flush, error-flag passthrough and a
// saturating stall-cycle counter. in_ready depends only on registered state.
module pipe_skid_reg #(
    parameter int               WIDTH     = 96,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_err,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] main_data;
    logic             main_err;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic             push;
    logic             pop;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_err   = main_err;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Registers are returned to FLUSH_VAL whenever they stop holding an entry,
    // so the outputs show FLUSH_VAL in EMPTY without an extra output mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= FLUSH_VAL;
            main_err  <= 1'b0;
            skid_data <= FLUSH_VAL;
            skid_err  <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            main_data <= FLUSH_VAL;
            main_err  <= 1'b0;
            skid_data <= FLUSH_VAL;
            skid_err  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_data <= in_data;
                        main_err  <= in_err;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_data <= in_data;
                        main_err  <= in_err;
                    end else if (pop) begin
                        main_data <= FLUSH_VAL;
                        main_err  <= 1'b0;
                        state     <= EMPTY;
                    end else if (push) begin
                        skid_data <= in_data;
                        skid_err  <= in_err;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_data <= skid_data;
                        main_err  <= skid_err;
                        skid_data <= FLUSH_VAL;
                        skid_err  <= 1'b0;
                        state     <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed vector table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [95:0] in_data;
    logic        in_err;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [95:0] out_data;
    logic        out_err;
    logic [15:0] stall_cnt;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [7:0]  sat_out_data;
    logic        sat_out_err;
    logic [1:0]  sat_stall_cnt;

    int checks;
    int errors;

    typedef struct {
        logic [95:0] data;
        logic        err;
    } entry_t;

    entry_t      q[$];
    int unsigned m_stall;
    int unsigned m_stall_sat;

    typedef struct {
        logic        v;
        logic        r;
        logic [95:0] d;
        logic        e;
        logic        f;
        logic        ov;
        logic        ir;
        logic [95:0] od;
        logic        oe;
        int unsigned sc;
    } vec_t;

    vec_t tbl[23];

    pipe_skid_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_err    (in_err),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .stall_cnt (stall_cnt)
    );

    pipe_skid_reg #(
        .WIDTH     (8),
        .CNT_W     (2),
        .FLUSH_VAL (8'h5A)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (sat_in_ready),
        .in_data   (in_data[7:0]),
        .in_err    (in_err),
        .flush     (flush),
        .out_valid (sat_out_valid),
        .out_ready (out_ready),
        .out_data  (sat_out_data),
        .out_err   (sat_out_err),
        .stall_cnt (sat_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_stall     = 0;
        m_stall_sat = 0;
    endtask

    // Queue model: entries leave in order, capacity two, flush empties it.
    task automatic modelStep(input logic v, input logic r, input logic [95:0] d,
                             input logic e, input logic f);
        bit     have;
        bit     room;
        entry_t ent;
        have = (q.size() > 0);
        room = (q.size() < 2);
        if (have && !r) begin
            if (m_stall < 65535) m_stall++;
            if (m_stall_sat < 3) m_stall_sat++;
        end
        if (f) begin
            q.delete();
        end else begin
            if (have && r) void'(q.pop_front());
            if (v && room) begin
                ent.data = d;
                ent.err  = e;
                q.push_back(ent);
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic r, input logic [95:0] d,
                                 input logic e, input logic f);
        in_valid  = v;
        out_ready = r;
        in_data   = d;
        in_err    = e;
        flush     = f;
        @(posedge clk);
        modelStep(v, r, d, e, f);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        logic [95:0] exp_d;
        logic        exp_e;
        logic [7:0]  exp_sd;
        exp_d  = (q.size() > 0) ? q[0].data : 96'h0;
        exp_e  = (q.size() > 0) ? q[0].err : 1'b0;
        exp_sd = (q.size() > 0) ? q[0].data[7:0] : 8'h5A;
        checkVal({tag, ".out_valid"}, 128'(out_valid), 128'(q.size() > 0));
        checkVal({tag, ".in_ready"},  128'(in_ready),  128'(q.size() < 2));
        checkVal({tag, ".out_data"},  128'(out_data),  128'(exp_d));
        checkVal({tag, ".out_err"},   128'(out_err),   128'(exp_e));
        checkVal({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(m_stall));
        checkVal({tag, ".sat_data"},  128'(sat_out_data),  128'(exp_sd));
        checkVal({tag, ".sat_err"},   128'(sat_out_err),   128'(exp_e));
        checkVal({tag, ".sat_stall"}, 128'(sat_stall_cnt), 128'(m_stall_sat));
    endtask

    function automatic vec_t mk(input logic v, input logic r, input logic [95:0] d,
                                input logic e, input logic f, input logic ov,
                                input logic ir, input logic [95:0] od, input logic oe,
                                input int unsigned sc);
        vec_t t;
        t.v = v; t.r = r; t.d = d; t.e = e; t.f = f;
        t.ov = ov; t.ir = ir; t.od = od; t.oe = oe; t.sc = sc;
        return t;
    endfunction

    initial begin
        logic [95:0] dval;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_err    = 1'b0;
        flush     = 1'b0;
        modelReset();

        // streaming, stall/drain, error neighbours, flush in FULL and in ONE
        tbl[0]  = mk(1, 1, 96'hA1, 0, 0,  1, 1, 96'hA1, 0, 0);
        tbl[1]  = mk(1, 1, 96'hB2, 0, 0,  1, 1, 96'hB2, 0, 0);
        tbl[2]  = mk(1, 1, 96'hC3, 0, 0,  1, 1, 96'hC3, 0, 0);
        tbl[3]  = mk(0, 1, 96'h0,  0, 0,  0, 1, 96'h0,  0, 0);
        tbl[4]  = mk(1, 0, 96'hA1, 0, 0,  1, 1, 96'hA1, 0, 0);
        tbl[5]  = mk(1, 0, 96'hB2, 0, 0,  1, 0, 96'hA1, 0, 1);
        tbl[6]  = mk(0, 0, 96'h0,  0, 0,  1, 0, 96'hA1, 0, 2);
        tbl[7]  = mk(0, 0, 96'h0,  0, 0,  1, 0, 96'hA1, 0, 3);
        tbl[8]  = mk(0, 0, 96'h0,  0, 0,  1, 0, 96'hA1, 0, 4);
        tbl[9]  = mk(0, 1, 96'h0,  0, 0,  1, 1, 96'hB2, 0, 4);
        tbl[10] = mk(0, 1, 96'h0,  0, 0,  0, 1, 96'h0,  0, 4);
        tbl[11] = mk(1, 0, 96'hD1, 0, 0,  1, 1, 96'hD1, 0, 4);
        tbl[12] = mk(1, 0, 96'hD2, 1, 0,  1, 0, 96'hD1, 0, 5);
        tbl[13] = mk(0, 1, 96'h0,  0, 0,  1, 1, 96'hD2, 1, 5);
        tbl[14] = mk(1, 1, 96'hD3, 0, 0,  1, 1, 96'hD3, 0, 5);
        tbl[15] = mk(0, 1, 96'h0,  0, 0,  0, 1, 96'h0,  0, 5);
        tbl[16] = mk(1, 0, 96'hE1, 0, 0,  1, 1, 96'hE1, 0, 5);
        tbl[17] = mk(1, 0, 96'hE2, 0, 0,  1, 0, 96'hE1, 0, 6);
        tbl[18] = mk(1, 0, 96'hE3, 0, 1,  0, 1, 96'h0,  0, 7);
        tbl[19] = mk(0, 1, 96'h0,  0, 0,  0, 1, 96'h0,  0, 7);
        tbl[20] = mk(1, 0, 96'hF1, 0, 0,  1, 1, 96'hF1, 0, 7);
        tbl[21] = mk(1, 1, 96'hF2, 0, 1,  0, 1, 96'h0,  0, 7);
        tbl[22] = mk(0, 1, 96'h0,  0, 0,  0, 1, 96'h0,  0, 7);

        repeat (2) @(negedge clk);
        checkVal("reset.out_valid", 128'(out_valid), 128'(0));
        checkVal("reset.in_ready",  128'(in_ready),  128'(1));
        checkVal("reset.out_data",  128'(out_data),  128'(0));
        checkVal("reset.stall_cnt", 128'(stall_cnt), 128'(0));
        checkVal("reset.sat_data",  128'(sat_out_data), 128'(8'h5A));
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            applyStimulus(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].e, tbl[i].f);
            checkVal($sformatf("row%0d.out_valid", i), 128'(out_valid), 128'(tbl[i].ov));
            checkVal($sformatf("row%0d.in_ready", i),  128'(in_ready),  128'(tbl[i].ir));
            checkVal($sformatf("row%0d.out_data", i),  128'(out_data),  128'(tbl[i].od));
            checkVal($sformatf("row%0d.out_err", i),   128'(out_err),   128'(tbl[i].oe));
            checkVal($sformatf("row%0d.stall_cnt", i), 128'(stall_cnt), 128'(tbl[i].sc));
            checkVal($sformatf("row%0d.sat_stall", i), 128'(sat_stall_cnt),
                     128'((tbl[i].sc > 3) ? 3 : tbl[i].sc));
            checkOutput($sformatf("row%0d.model", i));
        end

        // Asynchronous reset between edges while FULL
        applyStimulus(1, 0, 96'h11, 0, 0);
        applyStimulus(1, 0, 96'h22, 0, 0);
        checkVal("full.in_ready", 128'(in_ready), 128'(0));
        #2;
        rst = 1'b1;
        #1;
        checkVal("arst.out_valid", 128'(out_valid), 128'(0));
        checkVal("arst.stall_cnt", 128'(stall_cnt), 128'(0));
        checkVal("arst.in_ready",  128'(in_ready),  128'(1));
        checkVal("arst.out_data",  128'(out_data),  128'(0));
        checkVal("arst.sat_stall", 128'(sat_stall_cnt), 128'(0));
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 0, 96'hD00D, 0, 0);
        checkVal("arst.first_push", 128'(out_data), 128'(96'hD00D));
        checkOutput("arst.model");

        // Long stall saturates the narrow counter at 3
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 96'h0, 0, 0);
        checkVal("sat.stall_cnt_wide", 128'(stall_cnt), 128'(6));
        checkVal("sat.stall_cnt_narrow", 128'(sat_stall_cnt), 128'(3));
        checkOutput("sat.model");
        applyStimulus(0, 1, 96'h0, 0, 0);
        checkOutput("sat.drain");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            dval = {$urandom, $urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                          dval, 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 19) == 0));
            checkOutput($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: WIDTH, default 96, payload width in bits (pc + instr + pcPlus4).
REQ-002 Parameter: CNT_W, default 16, width of the stall-cycle counter.
REQ-003 Parameter: FLUSH_VAL, default all-zero WIDTH-bit value, out_data value whenever the stage holds no valid entry.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: in_valid  input  1  upstream presents a valid entry.
REQ-007 Port: in_ready  output  1  stage can accept an entry this cycle.
REQ-008 Port: in_data  input  WIDTH  upstream payload.
REQ-009 Port: in_err  input  1  error flag travelling with the payload.
REQ-010 Port: flush  input  1  synchronous kill of all held entries.
REQ-011 Port: out_valid  output  1  stage presents a valid entry.
REQ-012 Port: out_ready  input  1  downstream accepts the entry this cycle (low = stall).
REQ-013 Port: out_data  output  WIDTH  payload of the oldest held entry.
REQ-014 Port: out_err  output  1  error flag of the oldest held entry.
REQ-015 Port: stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Two-entry skid buffer: a main register (drives outputs) and a skid register; FSM states EMPTY, ONE, FULL.
REQ-017 in_ready = (state != FULL), decoded from registered state only, with no combinational path from out_ready.
REQ-018 out_valid = (state != EMPTY); out_data/out_err come from the main register; in EMPTY, out_data = FLUSH_VAL and out_err = 0.
REQ-019 Push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-020 EMPTY: a push loads main and moves to ONE; the entry appears on the outputs the next cycle (1-cycle latency).
REQ-021 ONE, push & pop: main loads the new entry; state stays ONE.
REQ-022 ONE, pop only: moves to EMPTY.
REQ-023 ONE, push only: skid loads the new entry; moves to FULL.
REQ-024 FULL, pop: main loads skid; moves to ONE. No push is possible in FULL.
REQ-025 Entries leave in acceptance order; no entry is duplicated or dropped except by flush.
REQ-026 in_err is stored and travels with its payload through main and skid identically.
REQ-027 flush=1 has priority over push and pop: next state is EMPTY, both registers are cleared to FLUSH_VAL/err 0, and an entry pushed in the same cycle is discarded.
REQ-028 A pop in the flush cycle still counts as consumed by downstream; the block takes no further action for it.
REQ-029 stall_cnt increments by 1 each cycle with out_valid=1 and out_ready=0, and saturates at 2^CNT_W-1 (no wrap).
REQ-030 flush does not clear stall_cnt; stall_cnt clears only on reset.

Reset
REQ-031 While rst=1: state=EMPTY, main and skid registers = FLUSH_VAL with err 0, stall_cnt=0, out_valid=0, in_ready=1.
REQ-032 Asserting rst mid-operation (state ONE or FULL) discards held entries immediately, without waiting for a clock edge.
REQ-033 The first push is accepted on the first rising edge after rst deasserts.

Verification
REQ-034 Streaming: out_ready=1, push A,B,C on consecutive cycles -> out_data A,B,C on the following cycles; state never reaches FULL; stall_cnt=0.
REQ-035 Stall: push A, B with out_ready=0 -> FULL, in_ready=0; hold out_ready=0 for 3 cycles -> stall_cnt=4; raise out_ready -> A, then B, and in_ready=1 after A pops.
REQ-036 Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_data=FLUSH_VAL, in_ready=1; the pushed entry never appears.
REQ-037 Error propagation: push A with in_err=1 while in FULL-to-ONE transitions -> out_err=1 exactly on A's output cycle and 0 for its neighbours.
REQ-038 Saturation: CNT_W=2, hold a stall for 6 cycles -> stall_cnt sticks at 3.
REQ-039 Async reset: assert rst between clock edges in FULL -> out_valid=0 and stall_cnt=0 before the next edge; after release, push D -> D is out the next cycle.
